// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared types and constants for the decode_issue stage.
//   - Opcode constants for the recognised instruction classes.
//   - reg_addr_t : architectural register address (x0..x31).
//   - decoded_t  : one decoded instruction as held in the issue register.
//   - decode_instr() : pure combinational decode of the opcode/register fields.
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t  ra1;
    reg_addr_t  ra2;
    reg_addr_t  wa;
    logic       we;
    logic       use_rs1;
    logic       use_rs2;
    logic [6:0] opcode;
    logic       illegal;
  } decoded_t;

  // Fields that an instruction class does not use are forced to zero so
  // the register file sees a quiet x0 read and the hazard check ignores them.
  function automatic decoded_t decode_instr(input logic [6:0] opcode,
                                            input reg_addr_t  rd,
                                            input reg_addr_t  rs1,
                                            input reg_addr_t  rs2);
    decoded_t d;
    d        = '0;
    d.opcode = opcode;
    case (opcode)
      OP_RTYPE: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.we      = (rd != '0);
      end
      OP_ITYPE, OP_LOAD: begin
        d.use_rs1 = 1'b1;
        d.we      = (rd != '0);
      end
      OP_STORE, OP_BRANCH: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    d.ra1 = d.use_rs1 ? rs1 : '0;
    d.ra2 = d.use_rs2 ? rs2 : '0;
    d.wa  = d.we      ? rd  : '0;
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// -----------------------------------------------------------------------------
// decode_issue_if
// Bundles the instruction handshake, the decoded-entry handshake, the
// writeback notification and flush for the decode_issue stage.
//   slave  : the decode_issue stage's view.
//   master : the surrounding pipeline's (or bench's) view.
// Signals:
//   in_valid/in_ready/in_instr      instruction input handshake
//   out_valid/out_ready             decoded entry handshake
//   out_ra1/out_ra2/out_wa/out_we   register file addresses and write enable
//   out_opcode/out_illegal          opcode passthrough, unrecognised opcode
//   wb_valid/wb_addr                writeback completion
//   flush                           discard the held entry
//   hazard_stall                    issue blocked by the scoreboard
// -----------------------------------------------------------------------------
interface decode_issue_if;
  import decode_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  reg_addr_t   out_ra1;
  reg_addr_t   out_ra2;
  reg_addr_t   out_wa;
  logic        out_we;
  logic [6:0]  out_opcode;
  logic        out_illegal;
  logic        wb_valid;
  reg_addr_t   wb_addr;
  logic        flush;
  logic        hazard_stall;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_addr, flush,
    output in_ready, out_valid, out_ra1, out_ra2, out_wa, out_we,
           out_opcode, out_illegal, hazard_stall
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_addr, flush,
    input  in_ready, out_valid, out_ra1, out_ra2, out_wa, out_we,
           out_opcode, out_illegal, hazard_stall
  );

endinterface

// File: rtl/decode_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// scoreboard
// Busy vector for registers with a write in flight.
//   clk, rst_n     clock, asynchronous active-low reset
//   i_set_en/addr  mark a register busy (issued write)
//   i_clr_en/addr  clear a register (writeback completed)
//   o_is_busy      per-register busy view used by the hazard check
// A set and a clear to the same register in one cycle leaves it busy: the
// newly issued write is the younger one. x0 is never tracked.
// Macro SCOREBOARD_BYPASS_EN: a same-cycle writeback hides the busy bit from
// the query so the dependent instruction can issue in the writeback cycle.
// -----------------------------------------------------------------------------
module scoreboard
  import decode_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_set_en,
  input  reg_addr_t       i_set_addr,
  input  logic            i_clr_en,
  input  reg_addr_t       i_clr_addr,
  output logic [NREG-1:0] o_is_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en && (i_clr_addr != '0)) w_busy_nxt[i_clr_addr] = 1'b0;
    // Applied after the clear so the set wins on a collision.
    if (i_set_en && (i_set_addr != '0)) w_busy_nxt[i_set_addr] = 1'b1;
  end

  // NOTE: the busy vector is control state, not a data array, so it is reset;
  // a stale busy bit after reset would stall issue forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

`ifdef SCOREBOARD_BYPASS_EN
  always_comb begin
    o_is_busy = r_busy;
    if (i_clr_en) o_is_busy[i_clr_addr] = 1'b0;
  end
`else
  assign o_is_busy = r_busy;
`endif

endmodule

// File: rtl/decode_issue.sv
// -----------------------------------------------------------------------------
// decode_issue
// Decode-and-issue stage feeding the register file. Decodes a 32-bit
// instruction into read addresses, write address/enable, opcode and illegal
// flag, holds the result in a single output register, and stalls issue on
// RAW/WAW hazards against writes still in flight.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    decode_issue_if.slave (handshakes, decoded fields, writeback, flush)
// Parameters: XLEN (register width, carried only), NREG (register count).
// Macro SCOREBOARD_BYPASS_EN: see scoreboard; lets a dependent instruction
// issue in the same cycle as the writeback that clears its hazard.
// -----------------------------------------------------------------------------
module decode_issue
  import decode_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input logic           clk,
  input logic           rst_n,
  decode_issue_if.slave bus
);

  decoded_t        w_dec;
  decoded_t        r_out;
  logic            r_out_valid;
  logic [NREG-1:0] w_is_busy;
  logic            w_held_we;
  logic            w_hazard;
  logic            w_accept;
  logic            w_set_en;

  // A register r hazards if it is busy, or if the held entry writes it and
  // has not yet been handed over (so the scoreboard has not counted it).
  function automatic logic reg_hazard(input logic            used,
                                      input reg_addr_t       r,
                                      input logic [NREG-1:0] busy_v,
                                      input logic            held_we,
                                      input reg_addr_t       held_wa);
    return used && (r != '0) && (busy_v[r] || (held_we && (held_wa == r)));
  endfunction

  assign w_dec = decode_instr(bus.in_instr[6:0],   bus.in_instr[11:7],
                              bus.in_instr[19:15], bus.in_instr[24:20]);

  assign w_held_we = r_out_valid && r_out.we;

  always_comb begin
    w_hazard = 1'b0;
    w_hazard = reg_hazard(w_dec.use_rs1, w_dec.ra1, w_is_busy, w_held_we, r_out.wa)
             | reg_hazard(w_dec.use_rs2, w_dec.ra2, w_is_busy, w_held_we, r_out.wa)
             | reg_hazard(w_dec.we,      w_dec.wa,  w_is_busy, w_held_we, r_out.wa);
  end

  assign bus.in_ready     = !bus.flush && !w_hazard && (!r_out_valid || bus.out_ready);
  assign bus.hazard_stall = bus.in_valid && w_hazard;
  assign w_accept         = bus.in_valid && bus.in_ready;

  // The handshake is honoured even in a flush cycle, so the write is counted.
  assign w_set_en = r_out_valid && bus.out_ready && r_out.we;

  scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_set_en),
    .i_set_addr (r_out.wa),
    .i_clr_en   (bus.wb_valid),
    .i_clr_addr (bus.wb_addr),
    .o_is_busy  (w_is_busy)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out       <= w_dec;
    end else if (bus.flush || bus.out_ready) begin
      // Data is left in place; only the valid drops.
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_ra1     = r_out.ra1;
  assign bus.out_ra2     = r_out.ra2;
  assign bus.out_wa      = r_out.wa;
  assign bus.out_we      = r_out.we;
  assign bus.out_opcode  = r_out.opcode;
  assign bus.out_illegal = r_out.illegal;

  // Instruction bits outside the decoded fields, the held source-use flags
  // and XLEN have no consumer in this stage.
  logic        w_unused;
  logic [31:0] w_unused_xlen;
  assign w_unused      = ^{bus.in_instr[31:25], bus.in_instr[14:12],
                           r_out.use_rs1, r_out.use_rs2};
  assign w_unused_xlen = 32'(XLEN);

endmodule

// File: tb/tb_decode_issue.sv
// -----------------------------------------------------------------------------
// tb_decode_issue
// Directed self-checking bench for decode_issue. Inputs are driven and
// outputs sampled just after the falling clock edge; the DUT updates on the
// rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_decode_issue;
  import decode_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  decode_issue_if bus();

  decode_issue #(.XLEN(64), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", dut.u_scoreboard.r_busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    n_checks++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hazard_stall: got %0b expected 0", bus.hazard_stall); end
    n_checks++; if ({bus.out_ra1, bus.out_ra2, bus.out_wa, bus.out_we, bus.out_opcode, bus.out_illegal} !== 24'h0) begin
      n_fail++; $display("FAIL reset_out_fields: got ra1=%0d ra2=%0d wa=%0d we=%0b op=%h ill=%0b expected all 0",
                         bus.out_ra1, bus.out_ra2, bus.out_wa, bus.out_we, bus.out_opcode, bus.out_illegal); end
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_rtype();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = enc(OP_RTYPE, 5'd3, 5'd1, 5'd2);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rtype_in_ready: got %0b expected 1", bus.in_ready); end
    cycle();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rtype_out_valid: got %0b expected 1", bus.out_valid); end
    n_checks++; if (bus.out_ra1 !== 5'd1) begin n_fail++; $display("FAIL rtype_ra1: got %0d expected 1", bus.out_ra1); end
    n_checks++; if (bus.out_ra2 !== 5'd2) begin n_fail++; $display("FAIL rtype_ra2: got %0d expected 2", bus.out_ra2); end
    n_checks++; if (bus.out_wa !== 5'd3) begin n_fail++; $display("FAIL rtype_wa: got %0d expected 3", bus.out_wa); end
    n_checks++; if (bus.out_we !== 1'b1) begin n_fail++; $display("FAIL rtype_we: got %0b expected 1", bus.out_we); end
    n_checks++; if (bus.out_opcode !== 7'h33) begin n_fail++; $display("FAIL rtype_opcode: got %h expected 33", bus.out_opcode); end
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h0) begin n_fail++; $display("FAIL rtype_busy_before_hs: got %h expected 0", dut.u_scoreboard.r_busy); end
    cycle();
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h8) begin n_fail++; $display("FAIL rtype_busy_after_hs: got %h expected 8", dut.u_scoreboard.r_busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rtype_drained: got %0b expected 0", bus.out_valid); end
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd3;
    cycle();
    bus.wb_valid = 1'b0;
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h0) begin n_fail++; $display("FAIL rtype_busy_cleared: got %h expected 0", dut.u_scoreboard.r_busy); end
  endtask

  task automatic test_raw();
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OP_RTYPE, 5'd3, 5'd1, 5'd2);
    cycle();
    bus.in_instr = enc(OP_ITYPE, 5'd4, 5'd3, 5'd0);
    #1;
    n_checks++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL raw_held_stall: got %0b expected 1", bus.hazard_stall); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_held_ready: got %0b expected 0", bus.in_ready); end
    cycle();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_not_issued: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL raw_busy_stall1: got %0b expected 1", bus.hazard_stall); end
    cycle();
    n_checks++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL raw_busy_stall2: got %0b expected 1", bus.hazard_stall); end
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd3;
    #1;
`ifdef SCOREBOARD_BYPASS_EN
    n_checks++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL raw_wb_cycle_stall: got %0b expected 0", bus.hazard_stall); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle_ready: got %0b expected 1", bus.in_ready); end
    cycle();
    bus.wb_valid = 1'b0;
`else
    n_checks++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle_stall: got %0b expected 1", bus.hazard_stall); end
    cycle();
    bus.wb_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_early_issue: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL raw_post_wb_stall: got %0b expected 0", bus.hazard_stall); end
    cycle();
`endif
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_issued: got %0b expected 1", bus.out_valid); end
    n_checks++; if ({bus.out_wa, bus.out_ra1} !== {5'd4, 5'd3}) begin
      n_fail++; $display("FAIL raw_fields: got wa=%0d ra1=%0d expected wa=4 ra1=3", bus.out_wa, bus.out_ra1); end
    cycle();
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h10) begin n_fail++; $display("FAIL raw_busy4: got %h expected 10", dut.u_scoreboard.r_busy); end
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd4;
    cycle();
    bus.wb_valid = 1'b0;
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h0) begin n_fail++; $display("FAIL raw_busy_end: got %h expected 0", dut.u_scoreboard.r_busy); end
  endtask

  task automatic test_no_write();
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OP_STORE, 5'd5, 5'd1, 5'd2);
    cycle();
    bus.in_instr = enc(OP_RTYPE, 5'd0, 5'd1, 5'd2);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %0b expected 1", bus.in_ready); end
    n_checks++; if ({bus.out_valid, bus.out_we, bus.out_wa, bus.out_illegal, bus.out_ra1, bus.out_ra2, bus.out_opcode}
                    !== {1'b1, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 7'h23}) begin
      n_fail++; $display("FAIL store_fields: got v=%0b we=%0b wa=%0d ill=%0b ra1=%0d ra2=%0d op=%h expected v=1 we=0 wa=0 ill=0 ra1=1 ra2=2 op=23",
                         bus.out_valid, bus.out_we, bus.out_wa, bus.out_illegal, bus.out_ra1, bus.out_ra2, bus.out_opcode); end
    cycle();
    bus.in_instr = enc(7'h7F, 5'd9, 5'd10, 5'd11);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2: got %0b expected 1", bus.in_ready); end
    n_checks++; if ({bus.out_valid, bus.out_we, bus.out_illegal, bus.out_ra1, bus.out_ra2, bus.out_opcode}
                    !== {1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 7'h33}) begin
      n_fail++; $display("FAIL rd0_fields: got v=%0b we=%0b ill=%0b ra1=%0d ra2=%0d op=%h expected v=1 we=0 ill=0 ra1=1 ra2=2 op=33",
                         bus.out_valid, bus.out_we, bus.out_illegal, bus.out_ra1, bus.out_ra2, bus.out_opcode); end
    cycle();
    bus.in_valid = 1'b0;
    n_checks++; if ({bus.out_valid, bus.out_we, bus.out_illegal, bus.out_ra1, bus.out_ra2, bus.out_opcode}
                    !== {1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 7'h7F}) begin
      n_fail++; $display("FAIL illegal_fields: got v=%0b we=%0b ill=%0b ra1=%0d ra2=%0d op=%h expected v=1 we=0 ill=1 ra1=0 ra2=0 op=7f",
                         bus.out_valid, bus.out_we, bus.out_illegal, bus.out_ra1, bus.out_ra2, bus.out_opcode); end
    cycle();
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h0) begin n_fail++; $display("FAIL nowrite_busy: got %h expected 0", dut.u_scoreboard.r_busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL nowrite_drained: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_hold_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = enc(OP_ITYPE, 5'd6, 5'd1, 5'd7);
    cycle();
    bus.in_instr  = enc(OP_RTYPE, 5'd7, 5'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({bus.out_valid, bus.out_wa, bus.out_ra1, bus.out_ra2, bus.out_we, bus.out_opcode}
                      !== {1'b1, 5'd6, 5'd1, 5'd0, 1'b1, 7'h13}) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got v=%0b wa=%0d ra1=%0d ra2=%0d we=%0b op=%h expected v=1 wa=6 ra1=1 ra2=0 we=1 op=13",
                           i, bus.out_valid, bus.out_wa, bus.out_ra1, bus.out_ra2, bus.out_we, bus.out_opcode); end
      n_checks++; if ({bus.in_ready, bus.hazard_stall} !== 2'b00) begin
        n_fail++; $display("FAIL hold_ready[%0d]: got ready=%0b stall=%0b expected 0 0", i, bus.in_ready, bus.hazard_stall); end
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b expected 0", bus.in_ready); end
    cycle();
    bus.flush = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h0) begin n_fail++; $display("FAIL flush_busy: got %h expected 0", dut.u_scoreboard.r_busy); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_set_wins();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = enc(OP_RTYPE, 5'd5, 5'd1, 5'd2);
    cycle();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd5;
    cycle();
    bus.wb_valid = 1'b0;
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h20) begin n_fail++; $display("FAIL set_wins: got %h expected 20", dut.u_scoreboard.r_busy); end
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OP_ITYPE, 5'd5, 5'd1, 5'd0);
    #1;
    n_checks++; if ({bus.hazard_stall, bus.in_ready} !== 2'b10) begin
      n_fail++; $display("FAIL waw_stall: got stall=%0b ready=%0b expected 1 0", bus.hazard_stall, bus.in_ready); end
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd9;
    cycle();
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h20) begin n_fail++; $display("FAIL wb_not_busy: got %h expected 20", dut.u_scoreboard.r_busy); end
    bus.wb_addr = 5'd0;
    cycle();
    bus.wb_valid = 1'b0;
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h20) begin n_fail++; $display("FAIL wb_x0: got %h expected 20", dut.u_scoreboard.r_busy); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = enc(OP_RTYPE, 5'd8, 5'd1, 5'd2);
    cycle();
    bus.in_valid = 1'b0;
    n_checks++; if ({bus.out_valid, bus.out_wa} !== {1'b1, 5'd8}) begin
      n_fail++; $display("FAIL mid_pre_held: got v=%0b wa=%0d expected v=1 wa=8", bus.out_valid, bus.out_wa); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.out_valid, bus.out_ra1, bus.out_ra2, bus.out_wa, bus.out_we, bus.out_opcode, bus.out_illegal} !== 25'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got v=%0b ra1=%0d ra2=%0d wa=%0d we=%0b op=%h ill=%0b expected all 0",
                         bus.out_valid, bus.out_ra1, bus.out_ra2, bus.out_wa, bus.out_we, bus.out_opcode, bus.out_illegal); end
    n_checks++; if (dut.u_scoreboard.r_busy !== 32'h0) begin n_fail++; $display("FAIL mid_reset_busy: got %h expected 0", dut.u_scoreboard.r_busy); end
    n_checks++; if ({bus.in_ready, bus.hazard_stall} !== 2'b10) begin
      n_fail++; $display("FAIL mid_reset_ready: got ready=%0b stall=%0b expected 1 0", bus.in_ready, bus.hazard_stall); end
    cycle();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.out_ready = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.flush     = 1'b0;

    test_reset();
    test_rtype();
    test_raw();
    test_no_write();
    test_hold_flush();
    test_set_wins();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
